// File: rtl/pattern_serializer_m.sv
// Serializes BPP*PIXELS pattern rows into one pixel per handshake, optionally mirrored.
// One row is serialized in the shifter while a second row waits in the hold register.
module pattern_serializer_m #(
    parameter int BPP    = 2,
    parameter int PIXELS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BPP*PIXELS-1:0] in_pattern,
    input  logic                  in_hflip,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BPP-1:0]        out_pixel,
    output logic                  out_first,
    output logic                  out_last
);

    // state  | meaning
    // S_IDLE | shifter empty, no pixel presented
    // S_BUSY | shifter holds a row, pixel idx presented on out_pixel
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam int W     = BPP * PIXELS;
    localparam int IDX_W = $clog2(PIXELS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS - 1);

    state_t           state;
    logic [W-1:0]     shreg;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     hold_pat;
    logic             hold_hflip;
    logic             hold_full;

    logic out_hs;
    logic in_hs;
    logic at_last;
    logic shifter_free;

    // The shifter always emits from its MSBs, so mirroring is applied once at load.
    function automatic logic [W-1:0] orient(input logic [W-1:0] pat, input logic hflip);
        logic [W-1:0] r;
        r = pat;
        if (hflip) begin
            for (int i = 0; i < PIXELS; i++) begin
                r[BPP*(i+1)-1 -: BPP] = pat[BPP*(PIXELS-i)-1 -: BPP];
            end
        end
        return r;
    endfunction

    assign at_last      = (idx == IDX_LAST);
    assign out_hs       = (state == S_BUSY) && out_ready;
    assign in_hs        = in_valid && !hold_full;
    assign shifter_free = (state == S_IDLE) || (at_last && out_hs);

    assign in_ready  = !hold_full;
    assign out_valid = (state == S_BUSY);
    assign out_pixel = shreg[W-1 -: BPP];
    assign out_first = (state == S_BUSY) && (idx == '0);
    assign out_last  = (state == S_BUSY) && at_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            idx        <= '0;
            hold_pat   <= '0;
            hold_hflip <= 1'b0;
            hold_full  <= 1'b0;
        end else if (shifter_free) begin
            idx <= '0;
            if (hold_full) begin
                // in_ready is low while hold_full, so no input row can collide here
                state     <= S_BUSY;
                shreg     <= orient(hold_pat, hold_hflip);
                hold_full <= 1'b0;
            end else if (in_hs) begin
                state <= S_BUSY;
                shreg <= orient(in_pattern, in_hflip);
            end else begin
                state <= S_IDLE;
            end
        end else begin
            if (out_hs) begin
                shreg <= {shreg[W-BPP-1:0], {BPP{1'b0}}};
                idx   <= idx + IDX_W'(1);
            end
            if (in_hs) begin
                hold_pat   <= in_pattern;
                hold_hflip <= in_hflip;
                hold_full  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_serializer_m.sv
// Directed bench for pattern_serializer_m: scoreboard fed on input handshakes,
// drained on output handshakes, plus a BPP=4/PIXELS=4 instance.
module tb_pattern_serializer_m;

    localparam int BPP = 2;
    localparam int PIX = 8;

    typedef struct packed {
        logic           first;
        logic           last;
        logic [BPP-1:0] pix;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, in_hflip, out_valid, out_ready, out_first, out_last;
    logic [BPP*PIX-1:0] in_pattern;
    logic [BPP-1:0]     out_pixel;

    logic        in_valid4, in_ready4, in_hflip4, out_valid4, out_ready4, out_first4, out_last4;
    logic [15:0] in_pattern4;
    logic [3:0]  out_pixel4;

    int errors = 0;
    int checks = 0;

    exp_t           sb[$];
    logic [BPP-1:0] seen[$];
    int             run = 0;
    int             last_run = 0;
    logic           prev_stall = 1'b0;
    logic [BPP-1:0] prev_pix;
    logic           prev_first, prev_last;

    logic [1:0] e031 [8] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [1:0] e032 [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [3:0] e036 [4] = '{4'd4, 4'd3, 4'd2, 4'd1};

    always #5 clk = ~clk;

    pattern_serializer_m #(.BPP(BPP), .PIXELS(PIX)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pattern(in_pattern), .in_hflip(in_hflip),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_first(out_first), .out_last(out_last)
    );

    pattern_serializer_m #(.BPP(4), .PIXELS(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_pattern(in_pattern4), .in_hflip(in_hflip4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_pixel(out_pixel4), .out_first(out_first4), .out_last(out_last4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_row(input logic [BPP*PIX-1:0] pat, input logic hf);
        exp_t e;
        for (int i = 0; i < PIX; i++) begin
            e.first = (i == 0);
            e.last  = (i == PIX - 1);
            e.pix   = hf ? pat[BPP*(i+1)-1 -: BPP] : pat[BPP*(PIX-i)-1 -: BPP];
            sb.push_back(e);
        end
    endtask

    // Monitor: all DUT sampling on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            run        = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_pixel", out_pixel, prev_pix);
                check("stall_first", out_first, prev_first);
                check("stall_last", out_last, prev_last);
            end
            if (in_valid && in_ready) push_row(in_pattern, in_hflip);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_pixel", out_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pixel", out_pixel, e.pix);
                    check("first", out_first, e.first);
                    check("last", out_last, e.last);
                    seen.push_back(out_pixel);
                end
            end
            if (out_valid) run++;
            else if (run != 0) begin
                last_run = run;
                run      = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_pix   = out_pixel;
            prev_first = out_first;
            prev_last  = out_last;
        end
    end

    // Leaves in_valid high; the caller decides what follows
    task automatic send_row(input logic [BPP*PIX-1:0] pat, input logic hf);
        logic done;
        done       = 1'b0;
        in_valid   = 1'b1;
        in_pattern = pat;
        in_hflip   = hf;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_seen(input string tag, input int base, input logic [1:0] e [8]);
        check({tag, "_count"}, seen.size() - base, 8);
        if (seen.size() - base >= 8) begin
            for (int i = 0; i < 8; i++) check({tag, "_px"}, seen[base+i], e[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        in_valid = 1'b0; in_pattern = '0; in_hflip = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_pattern4 = '0; in_hflip4 = 1'b0; out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_first", out_first, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_pixel", out_pixel, 0);
        @(posedge clk); #1;

        // Plain and mirrored single rows
        base = seen.size();
        send_row(16'hE400, 1'b0);
        in_valid = 1'b0;
        drain();
        check_seen("row_plain", base, e031);
        check("row_plain_run", last_run, 8);

        base = seen.size();
        send_row(16'hE400, 1'b1);
        in_valid = 1'b0;
        drain();
        check_seen("row_hflip", base, e032);

        // Three rows back-to-back
        send_row(16'hE400, 1'b0);
        send_row(16'h1B6C, 1'b1);
        @(negedge clk);
        check("hold_full_in_ready", in_ready, 0);
        send_row(16'hA5F0, 1'b0);
        in_valid = 1'b0;
        drain();
        check("b2b_run", last_run, 24);

        // Stalls mid-row
        send_row(16'h6C93, 1'b0);
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            out_ready = ~out_ready;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();

        // Reset at index 4 with a held row
        out_ready = 1'b0;
        send_row(16'hE400, 1'b0);
        send_row(16'hFFFF, 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_pixel", out_pixel, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        base = seen.size();
        send_row(16'h001B, 1'b0);
        in_valid = 1'b0;
        drain();
        check_seen("post_rst_row", base, e032);

        // BPP=4, PIXELS=4 mirrored
        in_valid4 = 1'b1; in_pattern4 = 16'h1234; in_hflip4 = 1'b1;
        @(negedge clk);
        check("w4_in_ready", in_ready4, 1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("w4_valid", out_valid4, 1);
            check("w4_pixel", out_pixel4, e036[i]);
            check("w4_first", out_first4, (i == 0));
            check("w4_last", out_last4, (i == 3));
        end
        @(negedge clk);
        check("w4_idle", out_valid4, 0);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
